mips_program_loader: RTL and testbench

Front-end stage for the single-cycle MIPS core. Receives the program as a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and writes them sequentially into instruction memory from address 0. When the final byte has been written it asserts `core_run`, releasing the core to fetch. Oversized programs are rejected with a sticky error, and the core is never released in that case.

---
 rtl/mips_program_loader_if.sv | 28 ++
 rtl/mips_program_loader.sv | 112 +++++++++++
 tb/tb_mips_program_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_program_loader_if.sv
// Byte-stream program load channel plus instruction-memory write port.
// master: stream source / memory sink side; slave: the loader.
//   in_valid/in_byte/in_last -> loader, in_ready <- loader
//   imem_we/imem_addr/imem_wdata, word_count, core_run, load_error <- loader
interface mips_program_loader_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic [7:0]            in_byte;
   logic                  in_last;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic [ADDR_WIDTH:0]   word_count;
   logic                  core_run;
   logic                  load_error;

   modport master (
      output in_valid, in_byte, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata, word_count, core_run, load_error
   );

   modport slave (
      input  in_valid, in_byte, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata, word_count, core_run, load_error
   );
endinterface

// File: rtl/mips_program_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words, writes
// them to instruction memory from address 0, then releases the core.
// Ports: clock, reset (async, active-high), bus (slave side of
// mips_program_loader_if: byte stream in, memory write port and status out).
module mips_program_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input logic                   clock,
   input logic                   reset,
   mips_program_loader_if.slave  bus
);
   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {LOAD, DONE, ERROR} state_t;

   state_t                state, state_nxt;
   logic [1:0]            idx, idx_nxt;
   logic [31:0]           asm_word, asm_nxt, merged;
   logic                  in_ready_q, in_ready_nxt;
   logic                  we_q, we_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [31:0]           wdata_q, wdata_nxt;
   logic [ADDR_WIDTH:0]   count_q, count_nxt;
   logic                  run_q, run_nxt;
   logic                  err_q, err_nxt;

   // State and all registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= LOAD;
         idx        <= 2'd0;
         asm_word   <= 32'd0;
         in_ready_q <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         count_q    <= '0;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         asm_word   <= asm_nxt;
         in_ready_q <= in_ready_nxt;
         we_q       <= we_nxt;
         addr_q     <= addr_nxt;
         wdata_q    <= wdata_nxt;
         count_q    <= count_nxt;
         run_q      <= run_nxt;
         err_q      <= err_nxt;
      end
   end

   // Next state, byte packing and write scheduling
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      asm_nxt   = asm_word;
      we_nxt    = 1'b0;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      count_nxt = count_q;

      // Lanes below the current index are still zero, so a partial word
      // written on in_last already has its unfilled low lanes cleared.
      case (idx)
         2'd0:    merged = {bus.in_byte, asm_word[23:0]};
         2'd1:    merged = {asm_word[31:24], bus.in_byte, asm_word[15:0]};
         2'd2:    merged = {asm_word[31:16], bus.in_byte, asm_word[7:0]};
         default: merged = {asm_word[31:8], bus.in_byte};
      endcase

      case (state)
         LOAD: begin
            if (bus.in_valid) begin
               if (count_q == FULL) begin
                  // Memory already full: drop the byte and lock out the core
                  state_nxt = ERROR;
               end else if (idx == 2'd3 || bus.in_last) begin
                  we_nxt    = 1'b1;
                  addr_nxt  = count_q[ADDR_WIDTH-1:0];
                  wdata_nxt = merged;
                  count_nxt = count_q + CW'(1);
                  asm_nxt   = 32'd0;
                  idx_nxt   = 2'd0;
                  if (bus.in_last) state_nxt = DONE;
               end else begin
                  asm_nxt = merged;
                  idx_nxt = idx + 2'd1;
               end
            end
         end
         DONE:    ;
         ERROR:   ;
         default: state_nxt = LOAD;
      endcase

      in_ready_nxt = (state_nxt == LOAD);
      // Lags entry into DONE by one edge so release follows the final strobe
      run_nxt      = (state == DONE);
      err_nxt      = (state_nxt == ERROR);
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.word_count = count_q;
   assign bus.core_run   = run_q;
   assign bus.load_error = err_q;
endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader: default-depth instance for load
// tests and a 4-word instance for overflow.
module tb_mips_program_loader;
   logic clock;
   logic reset;
   int   checks;
   int   errors;
   int   consec;
   logic prev8, prev2;

   logic [7:0]  a8_q[$];
   logic [31:0] d8_q[$];
   logic [1:0]  a2_q[$];
   logic [31:0] d2_q[$];

   mips_program_loader_if #(.ADDR_WIDTH(8)) b8 ();
   mips_program_loader_if #(.ADDR_WIDTH(2)) b2 ();

   mips_program_loader #(.ADDR_WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(b8.slave));
   mips_program_loader #(.ADDR_WIDTH(2)) dut2 (.clock(clock), .reset(reset), .bus(b2.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record every memory write and flag back-to-back strobes
   always @(posedge clock) begin
      if (b8.imem_we) begin
         a8_q.push_back(b8.imem_addr);
         d8_q.push_back(b8.imem_wdata);
         if (prev8) consec++;
      end
      if (b2.imem_we) begin
         a2_q.push_back(b2.imem_addr);
         d2_q.push_back(b2.imem_wdata);
         if (prev2) consec++;
      end
      prev8 = b8.imem_we;
      prev2 = b2.imem_we;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one byte (called at a negedge), return at the negedge after acceptance
   task automatic send(input bit sel, input logic [7:0] b, input logic last, input int gap);
      int   n;
      logic rdy;
      repeat (gap) @(negedge clock);
      if (sel) begin
         b2.in_valid = 1'b1; b2.in_byte = b; b2.in_last = last;
      end else begin
         b8.in_valid = 1'b1; b8.in_byte = b; b8.in_last = last;
      end
      n   = 0;
      rdy = sel ? b2.in_ready : b8.in_ready;
      while (!rdy && n < 20) begin
         @(negedge clock);
         n++;
         rdy = sel ? b2.in_ready : b8.in_ready;
      end
      if (!rdy) check("ready_timeout", 64'(rdy), 64'd1);
      @(negedge clock);
      b8.in_valid = 1'b0; b8.in_last = 1'b0;
      b2.in_valid = 1'b0; b2.in_last = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      a8_q.delete(); d8_q.delete();
      a2_q.delete(); d2_q.delete();
   endtask

   initial begin
      logic [7:0]  bytes14[14];
      logic [31:0] words4[4];
      logic [7:0]  bytes8[8];
      logic [31:0] words2[2];

      checks = 0; errors = 0; consec = 0;
      prev8 = 1'b0; prev2 = 1'b0;
      reset = 1'b0;
      b8.in_valid = 1'b0; b8.in_byte = 8'h00; b8.in_last = 1'b0;
      b2.in_valid = 1'b0; b2.in_byte = 8'h00; b2.in_last = 1'b0;

      // Reset values
      #1 reset = 1'b1;
      #1;
      check("rst_ready",  64'(b8.in_ready),   64'd1);
      check("rst_we",     64'(b8.imem_we),    64'd0);
      check("rst_addr",   64'(b8.imem_addr),  64'd0);
      check("rst_wdata",  64'(b8.imem_wdata), 64'd0);
      check("rst_count",  64'(b8.word_count), 64'd0);
      check("rst_run",    64'(b8.core_run),   64'd0);
      check("rst_err",    64'(b8.load_error), 64'd0);
      check("rst2_ready", 64'(b2.in_ready),   64'd1);
      @(negedge clock);
      reset = 1'b0;

      // Single full word
      send(1'b0, 8'h20, 1'b0, 0);
      send(1'b0, 8'h08, 1'b0, 0);
      send(1'b0, 8'h00, 1'b0, 0);
      send(1'b0, 8'h05, 1'b1, 0);
      check("w1_we",    64'(b8.imem_we),    64'd1);
      check("w1_addr",  64'(b8.imem_addr),  64'd0);
      check("w1_data",  64'(b8.imem_wdata), 64'h20080005);
      check("w1_count", 64'(b8.word_count), 64'd1);
      check("w1_run0",  64'(b8.core_run),   64'd0);
      check("w1_ready", 64'(b8.in_ready),   64'd0);
      @(negedge clock);
      check("w1_we_low", 64'(b8.imem_we),  64'd0);
      check("w1_run1",   64'(b8.core_run), 64'd1);
      repeat (2) @(negedge clock);
      check("w1_pulses", 64'(a8_q.size()), 64'd1);

      // Asynchronous reset mid-cycle takes effect without a clock edge
      #2 reset = 1'b1;
      #1;
      check("arst_run",   64'(b8.core_run),   64'd0);
      check("arst_count", 64'(b8.word_count), 64'd0);
      check("arst_wdata", 64'(b8.imem_wdata), 64'd0);
      check("arst_ready", 64'(b8.in_ready),   64'd1);
      @(negedge clock);
      reset = 1'b0;
      a8_q.delete(); d8_q.delete();

      // Three words plus a two-byte partial, contiguous
      bytes14 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hAB, 8'hCD};
      words4  = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hABCD0000};
      for (int i = 0; i < 14; i++) send(1'b0, bytes14[i], 1'(i == 13), 0);
      repeat (2) @(negedge clock);
      check("p_pulses", 64'(a8_q.size()),  64'd4);
      check("p_count",  64'(b8.word_count), 64'd4);
      check("p_run",    64'(b8.core_run),   64'd1);
      for (int i = 0; i < 4 && i < a8_q.size(); i++) begin
         check($sformatf("p_addr%0d", i), 64'(a8_q[i]), 64'(i));
         check($sformatf("p_data%0d", i), 64'(d8_q[i]), 64'(words4[i]));
      end

      // Gapped input
      do_reset();
      bytes8 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
      words2 = '{32'hDEADBEEF, 32'h01020304};
      for (int i = 0; i < 8; i++) send(1'b0, bytes8[i], 1'(i == 7), int'($urandom_range(0, 3)));
      repeat (3) @(negedge clock);
      check("g_pulses", 64'(a8_q.size()),  64'd2);
      check("g_count",  64'(b8.word_count), 64'd2);
      for (int i = 0; i < 2 && i < a8_q.size(); i++) begin
         check($sformatf("g_addr%0d", i), 64'(a8_q[i]), 64'(i));
         check($sformatf("g_data%0d", i), 64'(d8_q[i]), 64'(words2[i]));
      end

      // Reset after two bytes discards them; next load starts at address 0
      do_reset();
      send(1'b0, 8'hAA, 1'b0, 0);
      send(1'b0, 8'hBB, 1'b0, 0);
      do_reset();
      repeat (2) @(negedge clock);
      check("mr_no_write", 64'(a8_q.size()), 64'd0);
      send(1'b0, 8'h12, 1'b0, 0);
      send(1'b0, 8'h34, 1'b0, 0);
      send(1'b0, 8'h56, 1'b0, 0);
      send(1'b0, 8'h78, 1'b1, 0);
      repeat (2) @(negedge clock);
      check("mr_pulses", 64'(a8_q.size()), 64'd1);
      if (a8_q.size() > 0) begin
         check("mr_addr", 64'(a8_q[0]), 64'd0);
         check("mr_data", 64'(d8_q[0]), 64'h12345678);
      end
      check("mr_run", 64'(b8.core_run), 64'd1);

      // Overflow on the 4-word instance
      do_reset();
      for (int i = 0; i < 16; i++) send(1'b1, 8'(i + 1), 1'b0, 0);
      check("ov_full_ready", 64'(b2.in_ready),   64'd1);
      check("ov_full_err",   64'(b2.load_error), 64'd0);
      send(1'b1, 8'h11, 1'b0, 0);
      check("ov_err",   64'(b2.load_error), 64'd1);
      check("ov_ready", 64'(b2.in_ready),   64'd0);
      check("ov_run",   64'(b2.core_run),   64'd0);
      repeat (3) @(negedge clock);
      check("ov_pulses",  64'(a2_q.size()),   64'd4);
      check("ov_count",   64'(b2.word_count), 64'd4);
      check("ov_run_end", 64'(b2.core_run),   64'd0);
      check("ov_err_end", 64'(b2.load_error), 64'd1);
      for (int i = 0; i < 4 && i < a2_q.size(); i++) begin
         check($sformatf("ov_addr%0d", i), 64'(a2_q[i]), 64'(i));
         check($sformatf("ov_data%0d", i), 64'(d2_q[i]),
               {32'd0, 8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
      end

      check("no_b2b_we", 64'(consec), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
